// File: rtl/io_bus_responder_pkg.sv
// Shared constants for io_bus_responder: the bus width, the register map, the debounce count
// and the 7-segment digit table.
package io_bus_responder_pkg;

  localparam int unsigned DBITS     = 32;
  localparam int unsigned DEBCYCLES = 16;
  localparam int unsigned DEBCNTW   = $clog2(DEBCYCLES + 1);

  localparam logic [DBITS-1:0] ADDRHEX     = 32'hFFFFF000;
  localparam logic [DBITS-1:0] ADDRLEDR    = 32'hFFFFF020;
  localparam logic [DBITS-1:0] ADDRKEY     = 32'hFFFFF080;
  localparam logic [DBITS-1:0] ADDRKEYEDGE = ADDRKEY + 32'd4;
  localparam logic [DBITS-1:0] ADDRSW      = 32'hFFFFF090;

  // Active-low segment patterns {g,f,e,d,c,b,a} for the digits 0-F; entry i is digit i.
  localparam logic [15:0][6:0] SEG_TABLE = {
    7'b0001110, 7'b0000110, 7'b0100001, 7'b1000110,  // F E d C
    7'b0000011, 7'b0001000, 7'b0010000, 7'b0000000,  // b A 9 8
    7'b1111000, 7'b0000010, 7'b0010010, 7'b0011001,  // 7 6 5 4
    7'b0110000, 7'b0100100, 7'b1111001, 7'b1000000   // 3 2 1 0
  };

endpackage

// File: rtl/io_bus_responder_hex_to_seg7.sv
// Converts one hex digit into its active-low 7-segment pattern.
module hex_to_seg7
  import io_bus_responder_pkg::*;
(
  input  logic [3:0] digit_i,
  output logic [6:0] seg_o
);

  assign seg_o = SEG_TABLE[digit_i];

endmodule

// File: rtl/io_bus_responder.sv
// Memory-mapped I/O responder for HEX, LEDR, KEY and SW. Every access is acknowledged one cycle
// after req. Define IO_BUS_RESPONDER_DEBOUNCE_EN to debounce the KEY inputs.
module io_bus_responder
  import io_bus_responder_pkg::*;
(
  input  logic             clk,
  input  logic             reset,
  input  logic             req,
  input  logic             we,
  input  logic [DBITS-1:0] addr,
  input  logic [DBITS-1:0] wdata,
  output logic             hit,
  output logic             ack,
  output logic [DBITS-1:0] rdata,
  input  logic [3:0]       KEY,
  input  logic [9:0]       SW,
  output logic [6:0]       HEX0,
  output logic [6:0]       HEX1,
  output logic [6:0]       HEX2,
  output logic [6:0]       HEX3,
  output logic [6:0]       HEX4,
  output logic [6:0]       HEX5,
  output logic [9:0]       LEDR
);

  logic [23:0]      hex_q;
  logic [9:0]       ledr_q;
  logic [3:0]       edge_q, edge_d, key_prev_q, key_state, key_rise, key_clr;
  logic [3:0]       ksync1_q, ksync2_q;
  logic [9:0]       swsync1_q, swsync2_q;
  logic             ack_q;
  logic [DBITS-1:0] rdata_q, rdata_d;
  logic             sel_hex, sel_ledr, sel_key, sel_edge, sel_sw;
  logic             wr, rd;
  logic             unused_wdata;

  assign sel_hex  = (addr == ADDRHEX);
  assign sel_ledr = (addr == ADDRLEDR);
  assign sel_key  = (addr == ADDRKEY);
  assign sel_edge = (addr == ADDRKEYEDGE);
  assign sel_sw   = (addr == ADDRSW);
  assign hit      = sel_hex | sel_ledr | sel_key | sel_edge | sel_sw;

  assign wr = req & we;
  assign rd = req & ~we;
  assign unused_wdata = ^wdata[DBITS-1:24];

  always_comb begin
    rdata_d = '0;
    if (rd) begin
      if (sel_hex)       rdata_d[23:0] = hex_q;
      else if (sel_ledr) rdata_d[9:0]  = ledr_q;
      else if (sel_key)  rdata_d[3:0]  = key_state;
      else if (sel_edge) rdata_d[3:0]  = edge_q;
      else if (sel_sw)   rdata_d[9:0]  = swsync2_q;
    end
  end

  // A new rising edge beats a simultaneous write-1-to-clear of the same bit.
  assign key_rise = key_state & ~key_prev_q;
  assign key_clr  = (wr && sel_edge) ? wdata[3:0] : 4'b0000;
  assign edge_d   = (edge_q & ~key_clr) | key_rise;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      hex_q      <= '0;
      ledr_q     <= '0;
      edge_q     <= '0;
      key_prev_q <= '0;
      ksync1_q   <= 4'hF;
      ksync2_q   <= 4'hF;
      swsync1_q  <= '0;
      swsync2_q  <= '0;
      ack_q      <= 1'b0;
      rdata_q    <= '0;
    end else begin
      ksync1_q   <= KEY;
      ksync2_q   <= ksync1_q;
      swsync1_q  <= SW;
      swsync2_q  <= swsync1_q;
      key_prev_q <= key_state;
      edge_q     <= edge_d;
      ack_q      <= req;
      rdata_q    <= rdata_d;
      if (wr && sel_hex)  hex_q  <= wdata[23:0];
      if (wr && sel_ledr) ledr_q <= wdata[9:0];
    end
  end

`ifdef IO_BUS_RESPONDER_DEBOUNCE_EN
  logic [3:0]              key_db_q;
  logic [3:0][DEBCNTW-1:0] db_cnt_q;

  // A key differs from its debounced state while the synced (active-low) level equals that state.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      key_db_q <= '0;
      db_cnt_q <= '0;
    end else begin
      for (int k = 0; k < 4; k++) begin
        if (ksync2_q[k] == key_db_q[k]) begin
          if (db_cnt_q[k] == DEBCNTW'(DEBCYCLES - 1)) begin
            key_db_q[k] <= ~ksync2_q[k];
            db_cnt_q[k] <= '0;
          end else begin
            db_cnt_q[k] <= db_cnt_q[k] + 1'b1;
          end
        end else begin
          db_cnt_q[k] <= '0;
        end
      end
    end
  end

  assign key_state = key_db_q;
`else
  assign key_state = ~ksync2_q;
`endif

  logic [5:0][6:0] segs;

  for (genvar i = 0; i < 6; i++) begin : g_hex
    hex_to_seg7 u_hex_to_seg7 (
      .digit_i (hex_q[4*i +: 4]),
      .seg_o   (segs[i])
    );
  end

  assign HEX0  = segs[0];
  assign HEX1  = segs[1];
  assign HEX2  = segs[2];
  assign HEX3  = segs[3];
  assign HEX4  = segs[4];
  assign HEX5  = segs[5];
  assign LEDR  = ledr_q;
  assign ack   = ack_q;
  assign rdata = rdata_q;

endmodule
